// File: rtl/stream_demux.sv
// stream_demux: routes AXI-Stream-like packets from one slave port to one of
// M_DATA_COUNT master ports. The destination is latched on the first beat of a
// packet. Packets with an out-of-range destination are consumed and counted.
// A single output register gives one cycle of latency. It can drain and refill
// in the same cycle.

module stream_demux #(
  parameter  int unsigned M_DATA_COUNT = 3,
  parameter  int unsigned T_DATA_WIDTH = 8,
  localparam int unsigned T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [T_DATA_WIDTH-1:0]                   s_tdata_i,
  input  logic                                      s_tvalid_i,
  output logic                                      s_tready_o,
  input  logic                                      s_tlast_i,
  input  logic [T_DEST_WIDTH-1:0]                   s_tdest_i,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_tdata_o,
  output logic [M_DATA_COUNT-1:0]                   m_tvalid_o,
  output logic [M_DATA_COUNT-1:0]                   m_tlast_o,
  input  logic [M_DATA_COUNT-1:0]                   m_tready_i,
  output logic [7:0]                                drop_cnt_o
);

  localparam int unsigned M      = M_DATA_COUNT;
  localparam int unsigned DEST_X = T_DEST_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                  state;
  logic [T_DATA_WIDTH-1:0] data_q;
  logic [T_DEST_WIDTH-1:0] dest_q;
  logic [M-1:0]            valid_q;
  logic [M-1:0]            last_oh_q;

  logic                    full;
  logic                    drain;
  logic                    accept;
  logic                    dest_ok;
  logic                    load;
  logic                    drop_start;
  logic [T_DEST_WIDTH-1:0] route;
  logic [M-1:0]            dest_oh;

  // The held beat is tracked as a one-hot valid vector; full means any bit set.
  assign full  = |valid_q;
  assign drain = |(valid_q & m_tready_i);

  // Ready when empty, when the held beat leaves this cycle, or while discarding.
  assign s_tready_o = ~rst_i & ((state == DROP) | ~full | drain);
  assign accept     = s_tvalid_i & s_tready_o;

  // Compare one bit wider so that a power-of-two count never wraps.
  assign dest_ok = ({1'b0, s_tdest_i} < DEST_X'(M_DATA_COUNT));

  // The first beat takes s_tdest_i. Later beats reuse the locked destination.
  assign route   = (state == IDLE) ? s_tdest_i : dest_q;
  assign dest_oh = M'(1) << route;

  assign load       = accept & (((state == IDLE) & dest_ok) | (state == FWD));
  assign drop_start = accept & (state == IDLE) & ~dest_ok;

  // Output register: loads on an accepted beat, otherwise empties on drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      dest_q    <= '0;
      valid_q   <= '0;
      last_oh_q <= '0;
    end else if (load) begin
      data_q    <= s_tdata_i;
      dest_q    <= route;
      valid_q   <= dest_oh;
      last_oh_q <= s_tlast_i ? dest_oh : '0;
    end else if (drain) begin
      valid_q   <= '0;
      last_oh_q <= '0;
    end
  end

  // Packet framing FSM: IDLE waits for a first beat; FWD and DROP run until tlast.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!s_tlast_i) begin
            state <= dest_ok ? FWD : DROP;
          end
        end
        FWD, DROP: begin
          if (s_tlast_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count dropped packets once each, at their first beat; saturates at 255.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (drop_start && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

  assign m_tdata_o  = {M{data_q}};
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_oh_q;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter M_DATA_COUNT, default 3: number of master (output) streams, legal range 2..16.
REQ-002 Parameter T_DATA_WIDTH, default 8: tdata width in bits.
REQ-003 Localparam T_DEST_WIDTH = max(1, $clog2(M_DATA_COUNT)): tdest width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 s_tdata_i  input  T_DATA_WIDTH  slave-side beat data.
REQ-008 s_tvalid_i  input  1  slave-side beat valid.
REQ-009 s_tready_o  output  1  slave-side ready.
REQ-010 s_tlast_i  input  1  last beat of packet.
REQ-011 s_tdest_i  input  T_DEST_WIDTH  destination master index; sampled on first beat only.
REQ-012 m_tdata_o  output  [M_DATA_COUNT][T_DATA_WIDTH]  per-master data; all entries carry the held beat.
REQ-013 m_tvalid_o  output  M_DATA_COUNT  per-master valid, one-hot or zero.
REQ-014 m_tlast_o  output  M_DATA_COUNT  per-master last, qualified by m_tvalid_o.
REQ-015 m_tready_i  input  M_DATA_COUNT  per-master ready.
REQ-016 drop_cnt_o  output  8  count of dropped packets, saturating at 255.

Function
REQ-017 A beat SHALL transfer on a port when its tvalid and tready are both 1 on a rising edge.
REQ-018 The block SHALL hold one output register (data, last, dest, full flag); latency input-to-output is exactly 1 cycle.
REQ-019 s_tready_o SHALL be 1 when the register is empty, or when the register is full and m_tready_i[held dest] = 1 (same-cycle drain and refill), or in state DROP.
REQ-020 m_tvalid_o[k] SHALL be 1 only when the register is full and held dest = k; all other bits are 0.
REQ-021 The FSM SHALL have states IDLE, FWD and DROP.
REQ-022 IDLE: on an accepted beat with s_tdest_i < M_DATA_COUNT, the beat is loaded, dest locked to s_tdest_i; next state FWD, or IDLE if s_tlast_i = 1.
REQ-023 IDLE: on an accepted beat with s_tdest_i >= M_DATA_COUNT, the beat is discarded; next state DROP, or IDLE if s_tlast_i = 1; drop_cnt_o increments once for the packet.
REQ-024 FWD: each accepted beat is loaded with the locked dest, ignoring s_tdest_i; an accepted beat with s_tlast_i = 1 returns to IDLE.
REQ-025 DROP: s_tready_o = 1 and beats are discarded; an accepted tlast beat returns to IDLE; the held register keeps draining normally.
REQ-026 A new packet in IDLE SHALL be accepted while the previous packet's tlast beat is still held, with the same-cycle drain rule of REQ-019; back-to-back packets to different masters sustain 1 beat/cycle when readies are 1.
REQ-027 A held beat SHALL remain stable (data, last, dest) until its master accepts it; no reordering and no duplication.
REQ-028 drop_cnt_o SHALL saturate at 255 and never wrap.
REQ-029 Backpressure on one master SHALL stall only the input; no other master's tvalid asserts during the stall.

Reset
REQ-030 While rst_i = 1, the block SHALL force state IDLE, clear the full flag and set drop_cnt_o = 0, with m_tvalid_o = 0, m_tlast_o = 0 and s_tready_o = 0.
REQ-031 On the first cycle after rst_i deasserts, s_tready_o SHALL be 1.
REQ-032 A reset mid-packet SHALL discard the held beat and the route lock; the next accepted beat is treated as a packet start.

Verification
REQ-033 Packet of 4 beats, tdest = 2 on beat 0 and tdest toggled to 0 on beats 1-3, all readies 1 -> 4 beats appear on master 2 only, each 1 cycle after acceptance, tlast on the 4th.
REQ-034 Single-beat packets alternating tdest 0,1,0,1 back-to-back, readies 1 -> one beat per cycle, m_tvalid_o toggles 001/010, s_tready_o stays 1.
REQ-035 m_tready_i[1] = 0 for 5 cycles during a packet to master 1 -> s_tready_o = 0 after the register fills, held data stable, other m_tvalid_o bits stay 0, resumes with no loss.
REQ-036 Packet of 3 beats with tdest = 3 (M_DATA_COUNT = 3) -> all beats accepted, no m_tvalid_o, drop_cnt_o 0 -> 1; 300 such packets -> drop_cnt_o = 255.
REQ-037 Assert rst_i mid-packet with the register full -> m_tvalid_o = 0 next cycle, drop_cnt_o = 0; the next beat, with tdest = 1, routes to master 1 as a new packet.
